// File: rtl/id_ex_skid.sv
// id_ex_skid: decode-to-execute pipeline register with a one-entry skid buffer.
// The main register drives the execute-side outputs. The skid register absorbs
// one instruction when execute stalls, which lets in_ready depend only on
// registered state. A synchronous flush squashes every held instruction.
// Optional feature macro: IDEX_STALL_CNT_EN adds a free-running stall_cnt output.
module id_ex_skid #(
  parameter int CTRL_W = 12,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc4,
  input  logic [31:0]       in_rs_data,
  input  logic [31:0]       in_rt_data,
  input  logic [31:0]       in_imm,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  // pipeline control
  input  logic              flush,
  // execute side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc4,
  output logic [31:0]       out_rs_data,
  output logic [31:0]       out_rt_data,
  output logic [31:0]       out_imm,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Payload layout, LSB first: ctrl, rd, rt, imm, rt_data, rs_data, pc4.
  localparam int OFF_CTRL = 0;
  localparam int OFF_RD   = OFF_CTRL + CTRL_W;
  localparam int OFF_RT   = OFF_RD + REG_W;
  localparam int OFF_IMM  = OFF_RT + REG_W;
  localparam int OFF_RTD  = OFF_IMM + 32;
  localparam int OFF_RSD  = OFF_RTD + 32;
  localparam int OFF_PC4  = OFF_RSD + 32;
  localparam int PAY_W    = OFF_PC4 + 32;

  // Occupancy: EMPTY (main_v=0, skid_v=0), ONE (1,0), FULL (1,1).
  // The encoding puts main_v in bit 0 and skid_v in bit 1.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [PAY_W-1:0]   main_reg;
  logic [PAY_W-1:0]   main_next;
  logic [PAY_W-1:0]   skid_reg;
  logic [PAY_W-1:0]   skid_next;
  logic [PAY_W-1:0]   in_pay;
  logic               main_v;
  logic               skid_v;
  logic               accept;
  logic               consume;

  assign in_pay = {in_pc4, in_rs_data, in_rt_data, in_imm, in_rt, in_rd, in_ctrl};

  assign main_v = (state_reg == ST_ONE) || (state_reg == ST_FULL);
  assign skid_v = (state_reg == ST_FULL);

  // in_ready comes only from registered state, so out_ready never reaches it.
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign accept    = in_valid && in_ready;
  assign consume   = main_v && out_ready;

  // Next-state and payload-load decisions; flush overrides everything.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          main_next  = in_pay;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (consume && accept) begin
          main_next  = in_pay;
          state_next = ST_ONE;
        end else if (consume) begin
          state_next = ST_EMPTY;
        end else if (accept) begin
          skid_next  = in_pay;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (consume) begin
          main_next  = skid_reg;
          state_next = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
    if (flush) begin
      // Held payload goes stale; out_ctrl masking turns the bubble into a NOP.
      state_next = ST_EMPTY;
      main_next  = main_reg;
      skid_next  = skid_reg;
    end
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  assign out_pc4     = main_reg[OFF_PC4 +: 32];
  assign out_rs_data = main_reg[OFF_RSD +: 32];
  assign out_rt_data = main_reg[OFF_RTD +: 32];
  assign out_imm     = main_reg[OFF_IMM +: 32];
  assign out_rt      = main_reg[OFF_RT +: REG_W];
  assign out_rd      = main_reg[OFF_RD +: REG_W];

  // Control bits are forced to zero whenever no instruction is presented.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign out_ctrl[gi] = main_reg[OFF_CTRL + gi] & main_v;
    end
  endgenerate

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Count cycles where execute holds off a valid instruction; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (main_v && !out_ready) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// tb_id_ex_skid: directed and randomized bench for id_ex_skid. The reference
// model is a bounded queue of in-flight instructions (capacity two).
module tb_id_ex_skid;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [11:0] ctrl;
  } pay_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc4 = '0;
  logic [31:0] in_rs_data = '0;
  logic [31:0] in_rt_data = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [11:0] in_ctrl = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc4;
  logic [31:0] out_rs_data;
  logic [31:0] out_rt_data;
  logic [31:0] out_imm;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [11:0] out_ctrl;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  pay_t q[$];
  logic [31:0] stall_model = '0;

  always #5 clk = ~clk;

  id_ex_skid #(.CTRL_W(12), .REG_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc4(in_pc4),
    .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data),
    .in_imm(in_imm),
    .in_rt(in_rt),
    .in_rd(in_rd),
    .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc4(out_pc4),
    .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data),
    .out_imm(out_imm),
    .out_rt(out_rt),
    .out_rd(out_rd),
    .out_ctrl(out_ctrl)
`ifdef IDEX_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  function automatic pay_t mk(input logic [31:0] pc4);
    pay_t p;
    p.pc4  = pc4;
    p.rs   = $urandom;
    p.rtd  = $urandom;
    p.imm  = $urandom;
    p.rt   = 5'($urandom);
    p.rd   = 5'($urandom);
    p.ctrl = 12'($urandom) | 12'h001;
    return p;
  endfunction

  task automatic drive(input logic v, input pay_t p);
    in_valid   = v;
    in_pc4     = p.pc4;
    in_rs_data = p.rs;
    in_rt_data = p.rtd;
    in_imm     = p.imm;
    in_rt      = p.rt;
    in_rd      = p.rd;
    in_ctrl    = p.ctrl;
  endtask

  // One clock edge; the model is a queue: flush empties it, otherwise a
  // consumed head leaves and an accepted input (room for two) joins the tail.
  task automatic tick();
    pay_t c;
    bit   acc;
    bit   con;
    c   = {in_pc4, in_rs_data, in_rt_data, in_imm, in_rt, in_rd, in_ctrl};
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready) stall_model = stall_model + 32'd1;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(c);
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q.delete();
    stall_model = '0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    drive(1'b0, mk(32'h0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    pay_t p;
    #1;
    apply_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset0_out_valid: got %0b want 0", out_valid); end
    total++; if (out_ctrl !== 12'h0) begin bad++; $display("FAIL reset0_out_ctrl: got %h want 000", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset0_in_ready: got %0b want 1", in_ready); end
    release_reset();
    out_ready = 1'b0;
    drive(1'b1, mk(32'h100));
    tick();
    drive(1'b1, mk(32'h104));
    tick();
    drive(1'b0, mk(32'h0));
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_full_in_ready: got %0b want 0", in_ready); end
    total++; if (out_pc4 !== 32'h100) begin bad++; $display("FAIL reset_full_pc4: got %h want 00000100", out_pc4); end
    #2;
    apply_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_out_valid: got %0b want 0", out_valid); end
    total++; if (out_ctrl !== 12'h0) begin bad++; $display("FAIL reset_mid_out_ctrl: got %h want 000", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_in_ready: got %0b want 1", in_ready); end
    release_reset();
    p = mk(32'h200);
    p.imm = 32'hFFFF8000;
    drive(1'b1, p);
    tick();
    drive(1'b0, mk(32'h0));
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_first_valid: got %0b want 1", out_valid); end
    total++; if (out_imm !== 32'hFFFF8000) begin bad++; $display("FAIL reset_first_imm: got %h want ffff8000", out_imm); end
    total++; if (out_pc4 !== 32'h200) begin bad++; $display("FAIL reset_first_pc4: got %h want 00000200 (old entry leaked?)", out_pc4); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_drain_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    clear();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(32'(4 * (i + 1))));
      tick();
      total++; if (out_valid !== 1'b1 || out_pc4 !== 32'(4 * (i + 1))) begin
        bad++; $display("FAIL stream_%0d: got valid=%0b pc4=%h want valid=1 pc4=%h", i, out_valid, out_pc4, 32'(4 * (i + 1)));
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d: got %0b want 1", i, in_ready); end
    end
    drive(1'b0, mk(32'h0));
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    pay_t a;
    pay_t b;
    clear();
    a = mk(32'h10);
    b = mk(32'h14);
    out_ready = 1'b1;
    drive(1'b1, a);
    tick();
    out_ready = 1'b0;
    drive(1'b1, b);
    tick();
    drive(1'b0, mk(32'h0));
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready: got %0b want 0", in_ready); end
    total++; if (out_pc4 !== 32'h10) begin bad++; $display("FAIL bp_full_pc4: got %h want 00000010", out_pc4); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc4 !== 32'h10 || out_imm !== a.imm || out_ctrl !== a.ctrl) begin
      bad++; $display("FAIL bp_hold: got valid=%0b pc4=%h imm=%h ctrl=%h want 1 00000010 %h %h", out_valid, out_pc4, out_imm, out_ctrl, a.imm, a.ctrl);
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_pc4 !== 32'h14 || out_rs_data !== b.rs) begin
      bad++; $display("FAIL bp_drain_pc4: got pc4=%h rs=%h want 00000014 %h", out_pc4, out_rs_data, b.rs);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_in_ready: got %0b want 1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    clear();
    out_ready = 1'b0;
    drive(1'b1, mk(32'h10));
    tick();
    drive(1'b1, mk(32'h14));
    tick();
    flush = 1'b1;
    drive(1'b1, mk(32'h18));
    tick();
    flush = 1'b0;
    drive(1'b0, mk(32'h0));
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    total++; if (out_ctrl !== 12'h0) begin bad++; $display("FAIL flush_ctrl: got %h want 000", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_after_%0d: got valid=%0b pc4=%h want valid=0", i, out_valid, out_pc4); end
    end
  endtask

  task automatic test_consume_accept();
    clear();
    out_ready = 1'b1;
    drive(1'b1, mk(32'h20));
    tick();
    drive(1'b1, mk(32'h24));
    tick();
    drive(1'b0, mk(32'h0));
    total++; if (out_valid !== 1'b1 || out_pc4 !== 32'h24) begin
      bad++; $display("FAIL ca_pc4: got valid=%0b pc4=%h want 1 00000024", out_valid, out_pc4);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ca_in_ready: got %0b want 1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ca_no_dup: got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    pay_t e;
    clear();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, mk($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rand_valid_%0d: got %0b want %0b", i, out_valid, q.size() > 0); end
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rand_ready_%0d: got %0b want %0b", i, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        e = q[0];
        total++; if ({out_pc4, out_rs_data, out_rt_data, out_imm, out_rt, out_rd, out_ctrl} !== e) begin
          bad++; $display("FAIL rand_payload_%0d: got pc4=%h imm=%h ctrl=%h want pc4=%h imm=%h ctrl=%h", i, out_pc4, out_imm, out_ctrl, e.pc4, e.imm, e.ctrl);
        end
      end else begin
        total++; if (out_ctrl !== 12'h0) begin bad++; $display("FAIL rand_bubble_ctrl_%0d: got %h want 000", i, out_ctrl); end
      end
`ifdef IDEX_STALL_CNT_EN
      total++; if (stall_cnt !== stall_model) begin bad++; $display("FAIL rand_stall_%0d: got %0d want %0d", i, stall_cnt, stall_model); end
`endif
      tick();
    end
    flush = 1'b0;
  endtask

`ifdef IDEX_STALL_CNT_EN
  task automatic test_stall_cnt();
    apply_reset();
    release_reset();
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_reset: got %0d want 0", stall_cnt); end
    out_ready = 1'b0;
    drive(1'b1, mk(32'h40));
    tick();
    drive(1'b0, mk(32'h0));
    for (int i = 0; i < 5; i++) tick();
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_five: got %0d want 5", stall_cnt); end
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_after_flush: got %0d want 5", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_consume_accept();
    test_random();
`ifdef IDEX_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
- Decode-to-execute pipeline register for the mips32 core.
- Captures one decoded instruction per transfer: PC+4, both register-file read values, the 32-bit extended immediate, destination register fields and the control bundle.
- Presents that instruction to the execute stage through a valid/ready handshake.
- A one-entry skid buffer keeps full throughput under execute backpressure; synchronous flush squashes wrong-path instructions.

Parameters:
- CTRL_W, 12: width of the control bundle (ALU op, ALUSrc, RegDst, MemRead, MemWrite, RegWrite, MemtoReg, ...).
- REG_W, 5: register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  block can accept this cycle.
- in_pc4  in  32  PC+4 of the instruction.
- in_rs_data  in  32  rs read value.
- in_rt_data  in  32  rt read value.
- in_imm  in  32  extended immediate.
- in_rt  in  REG_W  rt field.
- in_rd  in  REG_W  rd field.
- in_ctrl  in  CTRL_W  control bundle.
- flush  in  1  squash all held instructions.
- out_valid  out  1  instruction available to execute.
- out_ready  in  1  execute consumes this cycle.
- out_pc4, out_rs_data, out_rt_data, out_imm  out  32 each  held payload.
- out_rt, out_rd  out  REG_W each  held payload.
- out_ctrl  out  CTRL_W  held control; all-zero whenever out_valid=0.
- stall_cnt  out  32  present only with the optional feature.

Behaviour:
- Clock and reset are fixed: single clock clk; reset rst_n is asynchronous and active-low.
- Storage: main register (main_v + payload) drives the outputs; skid register (skid_v + payload) holds one overflow entry.
- Reset (async, rst_n=0):
  - main_v=0, skid_v=0, all payload=0.
  - Hence out_valid=0, out_ctrl=0, in_ready=1.
  - Applies mid-operation and discards held entries.
- Handshakes:
  - in_ready = !skid_v, registered state only, no combinational path from out_ready.
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - out_valid = main_v.
- State (main_v, skid_v): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal.
- Transitions each rising edge, when flush=0:
  - EMPTY: on accept, main <= input, go to ONE.
  - ONE, consume and accept: main <= input, stay ONE.
  - ONE, consume only: go to EMPTY.
  - ONE, accept only: skid <= input, go to FULL.
  - ONE, neither: hold.
  - FULL, consume: main <= skid, skid_v=0, go to ONE. in_ready is 0 in FULL, so no accept occurs.
  - FULL, no consume: hold.
- Latency and ordering:
  - One cycle from accept to out_valid when EMPTY.
  - Sustained 1 instruction/cycle while out_ready=1.
  - Strict FIFO order; no entry is duplicated or dropped.
- Payload stability: while out_valid=1 and out_ready=0, every out_* stays constant.
- Flush (synchronous, highest priority):
  - Next state is EMPTY regardless of accept or consume.
  - An input presented in the flush cycle is discarded even if in_ready=1.
  - Payload registers may hold stale data, but out_ctrl reads 0 (bubble = NOP).
- Widths: payload passes through bit-exact; no arithmetic on data.

Optional Feature:
- Macro IDEX_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with out_valid=1 and out_ready=0.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset to 0 by rst_n only; not cleared by flush.
- Undefined: the stall_cnt port and its counter logic do not exist.

Test Plan:
- Reset: rst_n=0 mid-stream with FULL state -> out_valid=0, out_ctrl=0, in_ready=1 immediately; after release, first accepted in_imm=0xFFFF8000 appears as out_imm=0xFFFF8000 one cycle later.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with in_pc4=4,8,...,32 -> out_pc4 sequence 4..32 on consecutive cycles, no gaps.
- Backpressure: out_ready=0 after pc4=0x10 is in main, offer pc4=0x14 -> FULL, in_ready=0. Release out_ready -> out_pc4 shows 0x10 then 0x14, and in_ready returns to 1 the cycle after skid drains.
- Flush in FULL, with in_valid=1 and pc4=0x18 offered the same cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x18 never appears at the output.
- Simultaneous consume and accept in ONE with pc4 0x20 held and 0x24 offered -> next cycle out_pc4=0x24, state ONE, skid_v=0.
- With IDEX_STALL_CNT_EN: hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; then flush -> stall_cnt stays 5.
